// File: rtl/lcd_write_arbiter.sv
// Arbitrates the single SPI LCD write channel between init, char and pic word sources.
// One word is outstanding at a time; a wr_done watchdog recovers from a stalled writer.
module lcd_write_arbiter #(
    parameter int DATA_W      = 9,
    parameter int TIMEOUT_CYC = 5000,
    parameter int CNT_W       = 13
) (
    input  logic              sys_clk_50MHz,
    input  logic              sys_rst_n,
    input  logic              init_done,
    input  logic              init_valid,
    input  logic [DATA_W-1:0] init_data,
    output logic              init_ready,
    input  logic              char_valid,
    input  logic [DATA_W-1:0] char_data,
    input  logic              char_lock,
    output logic              char_ready,
    input  logic              pic_valid,
    input  logic [DATA_W-1:0] pic_data,
    input  logic              pic_lock,
    output logic              pic_ready,
    input  logic              wr_done,
    output logic [DATA_W-1:0] data,
    output logic              en_write,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_INIT = 2'b01;
    localparam logic [1:0] G_CHAR = 2'b10;
    localparam logic [1:0] G_PIC  = 2'b11;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_write_q, en_write_d;
    logic              init_ready_q, init_ready_d;
    logic              char_ready_q, char_ready_d;
    logic              pic_ready_q, pic_ready_d;
    logic [1:0]        grant_q, grant_d;
    logic              lock_q, lock_d;
    logic [CNT_W-1:0]  wd_q, wd_d;
    logic              timeout_err_q, timeout_err_d;
    logic              pic_first_q, pic_first_d;
    logic [1:0]        sel_s;

    // State, datapath and watchdog registers with synchronous active-low reset.
    always_ff @(posedge sys_clk_50MHz) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            data_q        <= {DATA_W{1'b0}};
            en_write_q    <= 1'b0;
            init_ready_q  <= 1'b0;
            char_ready_q  <= 1'b0;
            pic_ready_q   <= 1'b0;
            grant_q       <= G_NONE;
            lock_q        <= 1'b0;
            wd_q          <= {CNT_W{1'b0}};
            timeout_err_q <= 1'b0;
            pic_first_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            en_write_q    <= en_write_d;
            init_ready_q  <= init_ready_d;
            char_ready_q  <= char_ready_d;
            pic_ready_q   <= pic_ready_d;
            grant_q       <= grant_d;
            lock_q        <= lock_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
            pic_first_q   <= pic_first_d;
        end
    end

    // Source selection: a held lock restricts eligibility to its owner; before
    // init_done only init may write, afterwards char/pic alternate on a tie.
    always_comb begin
        sel_s = G_NONE;
        if (lock_q) begin
            if (grant_q == G_CHAR && char_valid) begin
                sel_s = G_CHAR;
            end else if (grant_q == G_PIC && pic_valid) begin
                sel_s = G_PIC;
            end else begin
                sel_s = G_NONE;
            end
        end else if (!init_done) begin
            sel_s = init_valid ? G_INIT : G_NONE;
        end else if (char_valid && pic_valid) begin
            sel_s = pic_first_q ? G_PIC : G_CHAR;
        end else if (char_valid) begin
            sel_s = G_CHAR;
        end else if (pic_valid) begin
            sel_s = G_PIC;
        end else begin
            sel_s = G_NONE;
        end
    end

    // Next-state logic: issue in IDLE, completion/lock sampling and watchdog in WAIT.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        en_write_d    = 1'b0;
        init_ready_d  = 1'b0;
        char_ready_d  = 1'b0;
        pic_ready_d   = 1'b0;
        grant_d       = grant_q;
        lock_d        = lock_q;
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
        pic_first_d   = pic_first_q;
        case (state_q)
            S_IDLE: begin
                if (sel_s != G_NONE) begin
                    state_d    = S_WAIT;
                    en_write_d = 1'b1;
                    grant_d    = sel_s;
                    wd_d       = {CNT_W{1'b0}};
                    case (sel_s)
                        G_INIT: begin
                            data_d       = init_data;
                            init_ready_d = 1'b1;
                        end
                        G_CHAR: begin
                            data_d       = char_data;
                            char_ready_d = 1'b1;
                            pic_first_d  = 1'b1;
                        end
                        default: begin
                            data_d      = pic_data;
                            pic_ready_d = 1'b1;
                            pic_first_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // wr_done takes priority over a coincident watchdog expiry.
                if (wr_done) begin
                    state_d = S_IDLE;
                    if ((grant_q == G_CHAR && char_lock) || (grant_q == G_PIC && pic_lock)) begin
                        lock_d = 1'b1;
                    end else begin
                        lock_d  = 1'b0;
                        grant_d = G_NONE;
                    end
                end else if (wd_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    lock_d        = 1'b0;
                    grant_d       = G_NONE;
                end else begin
                    wd_d = wd_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
                lock_d  = 1'b0;
                grant_d = G_NONE;
            end
        endcase
    end

    assign data        = data_q;
    assign en_write    = en_write_q;
    assign init_ready  = init_ready_q;
    assign char_ready  = char_ready_q;
    assign pic_ready   = pic_ready_q;
    assign grant       = grant_q;
    assign busy        = (state_q == S_WAIT);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: a per-cycle vector table plus hand-written
// sequences for round-robin, locking, watchdog and mid-transaction reset.
module tb_lcd_write_arbiter;

    localparam int DATA_W = 9;
    localparam int TO_CYC = 40;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_done, init_valid, char_valid, char_lock, pic_valid, pic_lock, wr_done;
    logic [DATA_W-1:0] init_data, char_data, pic_data;
    logic              init_ready, char_ready, pic_ready, en_write, busy, timeout_err;
    logic [DATA_W-1:0] data;
    logic [1:0]        grant;

    int checks   = 0;
    int failures = 0;

    lcd_write_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC), .CNT_W(CNT_W)) dut (
        .sys_clk_50MHz(clk), .sys_rst_n(rst_n),
        .init_done(init_done), .init_valid(init_valid), .init_data(init_data), .init_ready(init_ready),
        .char_valid(char_valid), .char_data(char_data), .char_lock(char_lock), .char_ready(char_ready),
        .pic_valid(pic_valid), .pic_data(pic_data), .pic_lock(pic_lock), .pic_ready(pic_ready),
        .wr_done(wr_done), .data(data), .en_write(en_write), .grant(grant),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        init_done;
        logic        init_valid;
        logic [8:0]  init_data;
        logic        char_valid;
        logic        pic_valid;
        logic        wr_done;
        logic        exp_en;
        logic [8:0]  exp_data;
        logic [2:0]  exp_rdy;
        logic [1:0]  exp_grant;
        logic        exp_busy;
        logic        exp_to;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {en_write, data, init_ready, char_ready, pic_ready, grant, busy, timeout_err};
    endfunction

    // Waits for the next en_write within a bounded number of cycles.
    task automatic wait_en(input string name);
        int n = 0;
        while (!en_write && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_en_seen"}, {31'd0, en_write}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; init_done = 1'b0; init_valid = 1'b0; char_valid = 1'b0; char_lock = 1'b0;
        pic_valid = 1'b0; pic_lock = 1'b0; wr_done = 1'b0;
        init_data = 9'h000; char_data = 9'h141; pic_data = 9'h1F8;

        // rst ido iv  idata  cv    pv    wd  | en   data    rdy{i,c,p} grant busy to
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'b000, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 9'h011, 1'b0, 1'b0, 1'b0, 1'b1, 9'h011, 3'b100, 2'b01, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0, 1'b0, 1'b0, 9'h011, 3'b000, 2'b01, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0, 1'b0, 1'b0, 9'h011, 3'b000, 2'b01, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0, 1'b0, 1'b0, 9'h011, 3'b000, 2'b01, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 9'h022, 1'b0, 1'b0, 1'b1, 1'b0, 9'h011, 3'b000, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 9'h022, 1'b0, 1'b0, 1'b0, 1'b1, 9'h022, 3'b100, 2'b01, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 9'h022, 1'b0, 1'b0, 1'b1, 1'b0, 9'h022, 3'b000, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 9'h022, 1'b1, 1'b1, 1'b0, 1'b0, 9'h022, 3'b000, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 9'h033, 1'b0, 1'b0, 1'b0, 1'b0, 9'h022, 3'b000, 2'b00, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 9'h033, 1'b0, 1'b0, 1'b1, 1'b0, 9'h022, 3'b000, 2'b00, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            rst_n = tbl[i].rst_n; init_done = tbl[i].init_done; init_valid = tbl[i].init_valid;
            init_data = tbl[i].init_data; char_valid = tbl[i].char_valid; pic_valid = tbl[i].pic_valid;
            wr_done = tbl[i].wr_done;
            tick();
            chk($sformatf("vec%0d", i), {15'd0, outs()},
                {15'd0, tbl[i].exp_en, tbl[i].exp_data, tbl[i].exp_rdy, tbl[i].exp_grant,
                 tbl[i].exp_busy, tbl[i].exp_to});
        end
        wr_done = 1'b0;

        // Before init_done, char/pic are never served.
        init_done = 1'b0; init_valid = 1'b0; char_valid = 1'b1; pic_valid = 1'b1;
        begin
            int en_cnt = 0;
            int gr_bad = 0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (en_write) en_cnt++;
                if (grant != 2'b00) gr_bad++;
            end
            chk("preinit_no_en", en_cnt, 0);
            chk("preinit_grant", gr_bad, 0);
        end

        // Round-robin: char, pic, char, pic with wr_done 3 cycles after each en_write.
        init_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_en($sformatf("rr%0d", k));
            chk($sformatf("rr%0d_data", k), {23'd0, data}, (k % 2 == 0) ? 32'h141 : 32'h1F8);
            chk($sformatf("rr%0d_rdy", k), {29'd0, init_ready, char_ready, pic_ready},
                (k % 2 == 0) ? 32'b010 : 32'b001);
            tick(); tick();
            wr_done = 1'b1;
            if (k == 3) begin
                char_valid = 1'b0; pic_valid = 1'b0;
            end
            tick();
            wr_done = 1'b0;
        end
        tick();
        chk("rr_idle_grant", {30'd0, grant}, 32'd0);

        // Pic locks the channel for 4 words while char waits.
        pic_valid = 1'b1; pic_lock = 1'b1;
        for (int w = 0; w < 4; w++) begin
            wait_en($sformatf("lk%0d", w));
            if (w == 0) char_valid = 1'b1;
            chk($sformatf("lk%0d_data", w), {23'd0, data}, 32'h1F8);
            chk($sformatf("lk%0d_grant", w), {30'd0, grant}, 32'd3);
            tick(); tick();
            wr_done = 1'b1;
            if (w == 3) pic_lock = 1'b0;
            tick();
            wr_done = 1'b0;
            chk($sformatf("lk%0d_grant_after", w), {30'd0, grant}, (w == 3) ? 32'd0 : 32'd3);
        end
        pic_valid = 1'b0;
        wait_en("lk_char");
        chk("lk_char_data", {23'd0, data}, 32'h141);
        char_valid = 1'b0;
        tick(); tick();
        wr_done = 1'b1; tick(); wr_done = 1'b0; tick();

        // Watchdog: no wr_done after an issue.
        char_valid = 1'b1;
        wait_en("to");
        char_valid = 1'b0;
        for (int c = 0; c < TO_CYC - 1; c++) tick();
        chk("to_before", {30'd0, busy, timeout_err}, 32'b10);
        tick();
        chk("to_fire", {28'd0, busy, timeout_err, grant}, 32'b0100);
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        chk("to_late_done", {29'd0, en_write, busy, timeout_err}, 32'b001);
        tick(); tick();
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset 2 cycles into a locked char word.
        char_valid = 1'b1; char_lock = 1'b1;
        wait_en("rst");
        char_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rst_outs", {15'd0, outs()}, 32'd0);
        rst_n = 1'b1; char_lock = 1'b0; pic_valid = 1'b1; wr_done = 1'b1;
        tick();
        wr_done = 1'b0; pic_valid = 1'b0;
        chk("rst_pic_issue", {19'd0, en_write, data, pic_ready, grant},
            {19'd0, 1'b1, 9'h1F8, 1'b1, 2'b11});
        tick();
        chk("rst_pic_busy", {31'd0, busy}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
